// File: rtl/split_dispenser.sv
// 1-to-2 fluid splitter: meters PULSE_W-cycle aliquots from the source and routes them alternately to A and B.
// Optional WAIT timeout is enabled by defining SPLIT_TIMEOUT_EN.
module split_dispenser #(
  parameter int unsigned PULSE_W = 8,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_aliq,
  input  logic       a_ready,
  input  logic       b_ready,
  output logic       valve_in,
  output logic       valve_a,
  output logic       valve_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SET_L, WAIT, ROUTE, SET_R, DONE
  } state_t;

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_W - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [7:0] tmr, tmr_nxt;
  logic [7:0] n_lat;
  logic [8:0] delivered;
  logic       tgt_b;
  logic       tgt_rdy;
  logic       accept;
  logic       inc_a;
  logic       inc_b;

  // Aliquot index equals the number already delivered; its LSB selects the outlet.
  assign delivered = {1'b0, cnt_a} + {1'b0, cnt_b};
  assign tgt_b     = delivered[0];
  assign tgt_rdy   = tgt_b ? b_ready : a_ready;

`ifdef SPLIT_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
`endif

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    accept    = 1'b0;
    inc_a     = 1'b0;
    inc_b     = 1'b0;
`ifdef SPLIT_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: begin
        tmr_nxt = 8'd0;
        if (start) begin
          if (n_aliq != 8'd0) begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        if (tmr == PULSE_LAST) begin
          tmr_nxt   = 8'd0;
          state_nxt = SET_L;
        end else begin
          tmr_nxt = tmr + 8'd1;
        end
      end
      SET_L: begin
        if (tmr == SETTLE_LAST) begin
          tmr_nxt   = 8'd0;
          state_nxt = tgt_rdy ? ROUTE : WAIT;
        end else begin
          tmr_nxt = tmr + 8'd1;
        end
      end
      WAIT: begin
        if (tgt_rdy) begin
          state_nxt = ROUTE;
        end
`ifdef SPLIT_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
`endif
      end
      ROUTE: begin
        // Pulse length is fixed once routing starts; ready is not looked at here.
        if (tmr == PULSE_LAST) begin
          tmr_nxt   = 8'd0;
          inc_a     = ~tgt_b;
          inc_b     = tgt_b;
          state_nxt = SET_R;
        end else begin
          tmr_nxt = tmr + 8'd1;
        end
      end
      SET_R: begin
        if (tmr == SETTLE_LAST) begin
          tmr_nxt   = 8'd0;
          state_nxt = (delivered == {1'b0, n_lat}) ? DONE : LOAD;
        end else begin
          tmr_nxt = tmr + 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= 8'd0;
      n_lat    <= 8'd0;
      cnt_a    <= 8'd0;
      cnt_b    <= 8'd0;
      valve_in <= 1'b0;
      valve_a  <= 1'b0;
      valve_b  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      // Valves decode the next state so they are registered yet aligned with the state.
      valve_in <= (state_nxt == LOAD);
      valve_a  <= (state_nxt == ROUTE) && !tgt_b;
      valve_b  <= (state_nxt == ROUTE) && tgt_b;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      if (accept) begin
        n_lat <= n_aliq;
        cnt_a <= 8'd0;
        cnt_b <= 8'd0;
      end else begin
        if (inc_a) cnt_a <= cnt_a + 8'd1;
        if (inc_b) cnt_b <= cnt_b + 8'd1;
      end
    end
  end

`ifdef SPLIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT && state_nxt == WAIT) ? wait_cnt + 1'b1 : '0;
      if (accept)       err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_split_dispenser.sv
// Directed self-checking bench for split_dispenser with default parameters.
module tb_split_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] n_aliq;
  logic       a_ready;
  logic       b_ready;
  logic       valve_in;
  logic       valve_a;
  logic       valve_b;
  logic       busy;
  logic       done;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  split_dispenser dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_aliq   (n_aliq),
    .a_ready  (a_ready),
    .b_ready  (b_ready),
    .valve_in (valve_in),
    .valve_a  (valve_a),
    .valve_b  (valve_b),
    .busy     (busy),
    .done     (done),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are then driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; n_aliq = 8'd3; a_ready = 1'b1; b_ready = 1'b1;
    step(); step();
    n_tests++;
    if ({valve_in, valve_a, valve_b, busy, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=000000", {valve_in, valve_a, valve_b, busy, done, err});
    end
    n_tests++;
    if ({cnt_a, cnt_b} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_counts got a=%0d b=%0d want 0 0", cnt_a, cnt_b);
    end
    rst = 1'b0; start = 1'b0;
    step();
  endtask

  // One aliquot to A with both outlets ready; start is driven in cycle 0.
  task automatic check_single(input string tag);
    logic [4:0] expv;
    n_aliq = 8'd1; a_ready = 1'b1; b_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 28; c++) begin
      if (c == 1) start = 1'b0;
      expv = {(c >= 1 && c <= 8), (c >= 13 && c <= 20), 1'b0, (c >= 1 && c <= 25), (c == 25)};
      n_tests++;
      if ({valve_in, valve_a, valve_b, busy, done} !== expv) begin
        n_fail++;
        $display("FAIL %s cycle %0d in/a/b/busy/done got=%b want=%b", tag, c,
                 {valve_in, valve_a, valve_b, busy, done}, expv);
      end
      step();
    end
    n_tests++;
    if (cnt_a !== 8'd1 || cnt_b !== 8'd0) begin
      n_fail++;
      $display("FAIL %s counts got a=%0d b=%0d want 1 0", tag, cnt_a, cnt_b);
    end
  endtask

  task automatic test_single();
    check_single("single");
  endtask

  // Five aliquots, start held and n_aliq changed while busy to show both are ignored.
  task automatic test_multi();
    int seq[$];
    int want[10] = '{1, 2, 1, 3, 1, 2, 1, 3, 1, 2};
    int dones = 0;
    int overlap = 0;
    logic [2:0] prev = 3'b0;
    n_aliq = 8'd5; a_ready = 1'b1; b_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 130; c++) begin
      if (c == 1) n_aliq = 8'd9;
      if (c == 100) start = 1'b0;
      if (valve_in && !prev[2]) seq.push_back(1);
      if (valve_a && !prev[1]) seq.push_back(2);
      if (valve_b && !prev[0]) seq.push_back(3);
      if (32'(valve_in) + 32'(valve_a) + 32'(valve_b) > 1) overlap++;
      if (done) dones++;
      prev = {valve_in, valve_a, valve_b};
      step();
    end
    n_tests++;
    if (seq.size() != 10) begin
      n_fail++;
      $display("FAIL multi_pulse_count got=%0d want=10", seq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (seq[i] != want[i]) begin
          n_fail++;
          $display("FAIL multi_order pulse %0d got=%0d want=%0d (1=in 2=a 3=b)", i, seq[i], want[i]);
        end
      end
    end
    n_tests++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL multi_exclusive overlapping cycles got=%0d want=0", overlap);
    end
    n_tests++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL multi_done_pulses got=%0d want=1", dones);
    end
    n_tests++;
    if (cnt_a !== 8'd3 || cnt_b !== 8'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_final got a=%0d b=%0d busy=%b want 3 2 0", cnt_a, cnt_b, busy);
    end
  endtask

  // Second aliquot waits for B: second SET_L ends in cycle 36, b_ready rises in cycle 56.
  task automatic test_wait();
    logic [3:0] expv;
    n_aliq = 8'd2; a_ready = 1'b1; b_ready = 1'b0; start = 1'b1;
    for (int c = 0; c < 72; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 56) b_ready = 1'b1;
      if (c == 60) b_ready = 1'b0;
      expv = {(c >= 1 && c <= 8) || (c >= 25 && c <= 32), (c >= 13 && c <= 20),
              (c >= 57 && c <= 64), (c == 69)};
      n_tests++;
      if ({valve_in, valve_a, valve_b, done} !== expv) begin
        n_fail++;
        $display("FAIL wait cycle %0d in/a/b/done got=%b want=%b", c, {valve_in, valve_a, valve_b, done}, expv);
      end
      step();
    end
    n_tests++;
    if (cnt_a !== 8'd1 || cnt_b !== 8'd1) begin
      n_fail++;
      $display("FAIL wait_counts got a=%0d b=%0d want 1 1", cnt_a, cnt_b);
    end
  endtask

  // Zero aliquots: done next cycle, no valve, counts from the previous run held.
  task automatic test_zero();
    logic [4:0] expv;
    n_aliq = 8'd0; a_ready = 1'b1; b_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) start = 1'b0;
      expv = {3'b000, (c == 1), (c == 1)};
      n_tests++;
      if ({valve_in, valve_a, valve_b, busy, done} !== expv) begin
        n_fail++;
        $display("FAIL zero cycle %0d in/a/b/busy/done got=%b want=%b", c,
                 {valve_in, valve_a, valve_b, busy, done}, expv);
      end
      step();
    end
    n_tests++;
    if (cnt_a !== 8'd1 || cnt_b !== 8'd1) begin
      n_fail++;
      $display("FAIL zero_counts_held got a=%0d b=%0d want 1 1", cnt_a, cnt_b);
    end
  endtask

  // Reset in cycle 15 (mid ROUTE), then a clean run.
  task automatic test_reset_mid();
    n_aliq = 8'd1; a_ready = 1'b1; b_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 1) start = 1'b0;
      step();
    end
    n_tests++;
    if (valve_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_route_open got valve_a=%b want=1", valve_a);
    end
    rst = 1'b1; start = 1'b1;
    step();
    n_tests++;
    if ({valve_in, valve_a, valve_b, busy, done, err, cnt_a, cnt_b} !== 22'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got=%b want all 0",
               {valve_in, valve_a, valve_b, busy, done, err, cnt_a, cnt_b});
    end
    rst = 1'b0; start = 1'b0;
    step();
    check_single("after_rst");
  endtask

  // Outlet A never ready: WAIT starts in cycle 13, 64 WAIT cycles end in cycle 76.
  task automatic test_timeout();
    int dones = 0;
    int vopen = 0;
    n_aliq = 8'd1; a_ready = 1'b0; b_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 82; c++) begin
      if (c == 1) start = 1'b0;
      if (done) dones++;
      if (c >= 13 && c <= 76 && (valve_in || valve_a || valve_b)) vopen++;
      step();
    end
    n_tests++;
    if (dones != 0 || vopen != 0) begin
      n_fail++;
      $display("FAIL timeout_quiet got done=%0d valve_cycles=%0d want 0 0", dones, vopen);
    end
`ifdef SPLIT_TIMEOUT_EN
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err got err=%b busy=%b want 1 0", err, busy);
    end
`else
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_forever got err=%b busy=%b want 0 1", err, busy);
    end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_aliq = 8'd0; a_ready = 1'b0; b_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_wait();
    test_zero();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
